// File: rtl/fft_sample_deserializer.sv
// Serial-to-parallel front end for the FFT sample path: frames a strobed
// bitstream into NUM_BITS-wide words and hands them out on valid/ready,
// flagging mid-word resyncs and words dropped against a full output.
module fft_sample_deserializer #(
  parameter int NUM_BITS  = 16,
  parameter bit SHIFT_MSB = 1'b1,
  parameter int CNT_W     = $clog2(NUM_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  input  logic                bit_strobe,
  input  logic                frame_sync,
  output logic [NUM_BITS-1:0] word_out,
  output logic                word_valid,
  input  logic                word_ready,
  output logic [CNT_W-1:0]    bit_count,
  output logic                overrun,
  output logic                frame_err,
  input  logic                err_clr
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SHIFT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_BITS-1:0] r_sr;
  logic [NUM_BITS-1:0] r_word;
  logic                r_valid;
  logic                r_overrun;
  logic                r_frame_err;

  logic [NUM_BITS-1:0] w_shift;
  logic                w_start;
  logic                w_resync;
  logic                w_complete;
  logic                w_full;

  // Next shift-register value; direction picks which end the first bit lands in.
  always_comb begin
    w_shift = r_sr;
    if (SHIFT_MSB) w_shift = {r_sr[NUM_BITS-2:0], serial_in};
    else           w_shift = {serial_in, r_sr[NUM_BITS-1:1]};
  end

  // Event decode. A sync on a non-zero count beats completion, so a sync on
  // the last bit slot discards the partial word instead of emitting it.
  always_comb begin
    w_start    = bit_strobe && frame_sync;
    w_resync   = bit_strobe && frame_sync && (r_state == ST_SHIFT) && (r_cnt != '0);
    w_complete = bit_strobe && (r_state == ST_SHIFT) && !w_resync && (r_cnt == CNT_LAST);
    w_full     = r_valid && !word_ready;
  end

  // Framing FSM, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sr    <= '1;
    end else if (bit_strobe) begin
      if (r_state == ST_IDLE) begin
        if (w_start) begin
          r_state <= ST_SHIFT;
          r_sr    <= w_shift;
          r_cnt   <= CNT_ONE;
        end
      end else begin
        r_sr <= w_shift;
        if (w_resync)        r_cnt <= CNT_ONE;
        else if (w_complete) r_cnt <= '0;
        else                 r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  // Output register: load on completion unless a held word is still waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else if (w_complete && !w_full) begin
      r_word  <= w_shift;
      r_valid <= 1'b1;
    end else if (r_valid && word_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky error flags; a set event in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (err_clr) begin
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_complete && w_full) r_overrun   <= 1'b1;
      if (w_resync)             r_frame_err <= 1'b1;
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign bit_count  = r_cnt;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_fft_sample_deserializer.sv
// Directed bench for fft_sample_deserializer: an MSB-first and an LSB-first
// instance (NUM_BITS=8) share one stimulus stream.
module tb_fft_sample_deserializer;

  logic       clk = 1'b0;
  logic       rst, serial_in, bit_strobe, frame_sync, word_ready, err_clr;
  logic [7:0] m_word, l_word;
  logic       m_valid, l_valid, m_ovr, l_ovr, m_ferr, l_ferr;
  logic [2:0] m_cnt, l_cnt;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  fft_sample_deserializer #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_strobe(bit_strobe),
    .frame_sync(frame_sync), .word_out(m_word), .word_valid(m_valid),
    .word_ready(word_ready), .bit_count(m_cnt), .overrun(m_ovr),
    .frame_err(m_ferr), .err_clr(err_clr));

  fft_sample_deserializer #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_strobe(bit_strobe),
    .frame_sync(frame_sync), .word_out(l_word), .word_valid(l_valid),
    .word_ready(word_ready), .bit_count(l_cnt), .overrun(l_ovr),
    .frame_err(l_ferr), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic fs);
    serial_in  = b;
    bit_strobe = 1'b1;
    frame_sync = fs;
    tick();
    bit_strobe = 1'b0;
    frame_sync = 1'b0;
  endtask

  // Bits go out w[7] first.
  task automatic send_word(input logic [7:0] w, input logic fs);
    for (int i = 7; i >= 0; i--) send(w[i], (i == 7) ? fs : 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] w;
    rst = 1'b1; serial_in = 1'b0; bit_strobe = 1'b0; frame_sync = 1'b0;
    word_ready = 1'b1; err_clr = 1'b0;

    // 1: reset held two cycles
    tick(); tick();
    chk("rst word",  m_word, 8'h00);
    chk("rst valid", m_valid, 1'b0);
    chk("rst cnt",   m_cnt, 3'd0);
    chk("rst ovr",   m_ovr, 1'b0);
    chk("rst ferr",  m_ferr, 1'b0);
    chk("rst lvalid", l_valid, 1'b0);
    rst = 1'b0;

    // 2: 1,0,1,0,0,1,0,1 -> A5 in both orders
    send(1'b1, 1'b1);
    chk("t2 cnt1", m_cnt, 3'd1);
    w = 8'hA5;
    for (int i = 6; i >= 1; i--) send(w[i], 1'b0);
    chk("t2 cnt7", m_cnt, 3'd7);
    chk("t2 novalid", m_valid, 1'b0);
    send(w[0], 1'b0);
    chk("t2 word",  m_word, 8'hA5);
    chk("t2 valid", m_valid, 1'b1);
    chk("t2 lword", l_word, 8'hA5);
    chk("t2 cnt0",  m_cnt, 3'd0);
    tick();
    chk("t2 valid1cyc", m_valid, 1'b0);

    // 3: 1,1,0,... -> C0 MSB-first, 03 LSB-first; sync at count 0 is clean
    send_word(8'hC0, 1'b1);
    chk("t3 msb", m_word, 8'hC0);
    chk("t3 lsb", l_word, 8'h03);
    chk("t3 noferr", m_ferr, 1'b0);
    tick();

    // 4: back-pressure and overrun
    word_ready = 1'b0;
    send_word(8'h11, 1'b0);
    chk("t4 w11", m_word, 8'h11);
    chk("t4 v11", m_valid, 1'b1);
    chk("t4 noovr", m_ovr, 1'b0);
    send_word(8'h22, 1'b0);
    chk("t4 keep11", m_word, 8'h11);
    chk("t4 ovr", m_ovr, 1'b1);
    w = 8'h33;
    for (int i = 7; i >= 1; i--) send(w[i], 1'b0);
    word_ready = 1'b1;
    send(w[0], 1'b0);
    word_ready = 1'b0;
    chk("t4 w33", m_word, 8'h33);
    chk("t4 v33", m_valid, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4 ovrclr", m_ovr, 1'b0);
    chk("t4 hold33", m_word, 8'h33);
    word_ready = 1'b1;
    tick();
    chk("t4 drained", m_valid, 1'b0);

    // 5: resync after 3 bits; new word 96 counted from the sync bit
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    chk("t5 cnt3", m_cnt, 3'd3);
    send(1'b1, 1'b1);
    chk("t5 ferr", m_ferr, 1'b1);
    chk("t5 cnt1", m_cnt, 3'd1);
    w = 8'h96;
    for (int i = 6; i >= 0; i--) send(w[i], 1'b0);
    chk("t5 word",  m_word, 8'h96);
    chk("t5 lword", l_word, 8'h69);
    chk("t5 valid", m_valid, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5 ferrclr", m_ferr, 1'b0);

    // 6: reset mid-word with a word pending, then IDLE ignores unsynced strobes
    word_ready = 1'b0;
    send_word(8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
    chk("t6 cnt5",  m_cnt, 3'd5);
    chk("t6 vpend", m_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6 rvalid", m_valid, 1'b0);
    chk("t6 rword",  m_word, 8'h00);
    chk("t6 rcnt",   m_cnt, 3'd0);
    word_ready = 1'b1;
    send_word(8'hFF, 1'b0);
    tick();
    chk("t6 idlecnt",   m_cnt, 3'd0);
    chk("t6 idlevalid", m_valid, 1'b0);
    send_word(8'h5A, 1'b1);
    chk("t6 w5A", m_word, 8'h5A);
    chk("t6 v5A", m_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
